// File: rtl/trace_buffer_pkg.sv
// Shared types for the retire-trace capture buffer: FSM encodings and the
// packed trace entry that flows through the FIFO.
package trace_buffer_pkg;

  localparam int ENTRY_W = 96;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] debug;
  } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO holding captured trace entries; reports occupancy and
// flags pushes that were dropped because the FIFO was full.
module trace_fifo
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  entry_t                   i_data,
  input  logic                     i_pop,
  output entry_t                   o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           push_ok;
  logic           pop_ok;

  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the push lands in; a pop on an empty
  // FIFO is not accepted, so there is no write-to-read bypass.
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);
  assign o_drop  = i_push && !push_ok;

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, so clearing the array would only add logic.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trace_buffer.sv
// Captures a triggered window of the core retire trace into a FIFO: arm,
// wait for the trigger PC, then record a fixed number of consecutive cycles.
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [31:0]             i_pc,
  input  logic [31:0]             i_inst,
  input  logic [31:0]             i_debug,
  input  logic                    i_arm,
  input  logic [31:0]             i_trig_pc,
  input  logic [LEN_W-1:0]        i_len,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [31:0]             o_pc,
  output logic [31:0]             o_inst,
  output logic [31:0]             o_debug,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [1:0]              o_state,
  output logic                    o_overflow
);

  state_e           state;
  logic [LEN_W-1:0] remaining;
  logic             overflow;
  logic             trig_hit;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  entry_t           wr_entry;
  entry_t           head;

  assign trig_hit = (state == ST_ARMED) && (i_pc == i_trig_pc);
  // Gating with reset keeps captures and pops out of the reset cycle.
  assign push     = !i_rst && (trig_hit || (state == ST_CAPTURE));
  assign pop      = !i_rst && i_ready;
  assign wr_entry = '{pc: i_pc, inst: i_inst, debug: i_debug};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (wr_entry),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_count),
    .o_drop  (drop)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_arm) begin
            state     <= ST_ARMED;
            remaining <= (i_len == '0) ? LEN_W'(1) : i_len;
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            remaining <= remaining - 1'b1;
            state     <= (remaining == LEN_W'(1)) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // Dropped pushes still consume length, so the window stays fixed.
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_state    = state;
  assign o_overflow = overflow;
  assign o_valid    = !fifo_empty;
  assign o_pc       = head.pc;
  assign o_inst     = head.inst;
  assign o_debug    = head.debug;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a table of per-cycle vectors for the basic
// capture/drain flow plus hand-written multi-cycle corner-case sequences.
module tb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, inst, debug, trig_pc;
  logic        arm, ready;
  logic [7:0]  len;
  logic        valid, overflow;
  logic [31:0] q_pc, q_inst, q_debug;
  logic [4:0]  count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  trace_buffer #(.DEPTH(16), .LEN_W(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_pc       (pc),
    .i_inst     (inst),
    .i_debug    (debug),
    .i_arm      (arm),
    .i_trig_pc  (trig_pc),
    .i_len      (len),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_pc       (q_pc),
    .o_inst     (q_inst),
    .o_debug    (q_debug),
    .o_count    (count),
    .o_state    (state),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        arm;
    logic [7:0]  len;
    logic [31:0] trig;
    logic [31:0] pc;
    logic        ready;
    logic [1:0]  st;
    logic [4:0]  cnt;
    logic        vld;
    logic        ovf;
    logic [31:0] hpc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] dbg_of(input logic [31:0] p);
    return ~p;
  endfunction

  function automatic vec_t mk(input logic r, input logic a, input logic [7:0] l,
                              input logic [31:0] t, input logic [31:0] p,
                              input logic rd, input logic [1:0] s,
                              input logic [4:0] c, input logic v,
                              input logic o, input logic [31:0] h);
    vec_t x;
    x.rst = r; x.arm = a; x.len = l; x.trig = t; x.pc = p; x.ready = rd;
    x.st = s; x.cnt = c; x.vld = v; x.ovf = o; x.hpc = h;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc    = p;
    inst  = inst_of(p);
    debug = dbg_of(p);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string name, input logic [31:0] p);
    check({name, " valid"}, {31'd0, valid}, 32'd1);
    check({name, " pc"},    q_pc,    p);
    check({name, " inst"},  q_inst,  inst_of(p));
    check({name, " debug"}, q_debug, dbg_of(p));
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; ready = 1'b0; len = '0; trig_pc = '0;
    set_pc(32'h0);
    step();

    // rst arm len trig pc ready | state cnt vld ovf headpc
    vecs.push_back(mk(1, 1, 8'd3, 32'h8, 32'h8,  1, 2'd0, 5'd0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 8'd3, 32'h8, 32'h0,  0, 2'd1, 5'd0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 8'd3, 32'h8, 32'h0,  0, 2'd1, 5'd0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 8'd7, 32'h8, 32'h4,  0, 2'd1, 5'd0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 8'd3, 32'h8, 32'h8,  0, 2'd2, 5'd1, 1, 0, 32'h8));
    vecs.push_back(mk(0, 1, 8'd3, 32'h8, 32'hC,  0, 2'd2, 5'd2, 1, 0, 32'h8));
    vecs.push_back(mk(0, 0, 8'd3, 32'h8, 32'h10, 0, 2'd3, 5'd3, 1, 0, 32'h8));
    vecs.push_back(mk(0, 0, 8'd3, 32'h8, 32'h14, 1, 2'd3, 5'd2, 1, 0, 32'hC));
    vecs.push_back(mk(0, 0, 8'd3, 32'h8, 32'h8,  1, 2'd3, 5'd1, 1, 0, 32'h10));
    vecs.push_back(mk(0, 0, 8'd3, 32'h8, 32'h18, 1, 2'd3, 5'd0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 8'd3, 32'h8, 32'h1C, 1, 2'd3, 5'd0, 0, 0, 32'h0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; arm = vecs[i].arm; len = vecs[i].len;
      trig_pc = vecs[i].trig; ready = vecs[i].ready;
      set_pc(vecs[i].pc);
      step();
      check($sformatf("vec%0d state", i), {30'd0, state}, {30'd0, vecs[i].st});
      check($sformatf("vec%0d count", i), {27'd0, count}, {27'd0, vecs[i].cnt});
      check($sformatf("vec%0d valid", i), {31'd0, valid}, {31'd0, vecs[i].vld});
      check($sformatf("vec%0d ovf", i),   {31'd0, overflow}, {31'd0, vecs[i].ovf});
      if (vecs[i].vld) check_head($sformatf("vec%0d head", i), vecs[i].hpc);
    end

    // Long window into a stalled consumer: 16 kept, 4 dropped.
    do_reset();
    arm = 1'b1; len = 8'd20; trig_pc = 32'h100; set_pc(32'h0);
    step();
    check("ovf armed", {30'd0, state}, 32'd1);
    arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_pc(32'h100 + 32'(4 * i));
      step();
      check($sformatf("ovf st%0d", i), {30'd0, state}, (i == 19) ? 32'd3 : 32'd2);
      check($sformatf("ovf cnt%0d", i), {27'd0, count}, (i < 16) ? 32'(i + 1) : 32'd16);
      check($sformatf("ovf flag%0d", i), {31'd0, overflow}, (i >= 16) ? 32'd1 : 32'd0);
    end
    check_head("ovf head", 32'h100);

    // Re-arm from DONE with len=0 keeps contents and the sticky flag; the
    // single trigger push lands on a full FIFO together with a pop.
    arm = 1'b1; len = 8'd0; trig_pc = 32'h500; set_pc(32'h0);
    step();
    arm = 1'b0;
    check("rearm state", {30'd0, state}, 32'd1);
    check("rearm count", {27'd0, count}, 32'd16);
    check("rearm ovf", {31'd0, overflow}, 32'd1);
    set_pc(32'h500); ready = 1'b1;
    step();
    set_pc(32'h0);
    check("len0 state", {30'd0, state}, 32'd3);
    check("full pushpop count", {27'd0, count}, 32'd16);
    for (int k = 0; k < 16; k++) begin
      check_head($sformatf("drain%0d", k), (k < 15) ? 32'h104 + 32'(4 * k) : 32'h500);
      step();
    end
    check("drain empty", {27'd0, count}, 32'd0);
    check("drain valid", {31'd0, valid}, 32'd0);
    check("drain ovf sticky", {31'd0, overflow}, 32'd1);

    // Streaming consumer: each entry appears one cycle after capture.
    do_reset();
    check("rst clears ovf", {31'd0, overflow}, 32'd0);
    arm = 1'b1; len = 8'd20; trig_pc = 32'h200; ready = 1'b1; set_pc(32'h0);
    step();
    arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_pc(32'h200 + 32'(4 * i));
      step();
      check_head($sformatf("stream%0d", i), 32'h200 + 32'(4 * i));
      check($sformatf("stream cnt%0d", i), {27'd0, count}, 32'd1);
    end
    set_pc(32'h0);
    check("stream done", {30'd0, state}, 32'd3);
    step();
    check("stream empty", {27'd0, count}, 32'd0);
    check("stream ovf", {31'd0, overflow}, 32'd0);

    // Reset in the middle of a capture window.
    ready = 1'b0;
    arm = 1'b1; len = 8'd10; trig_pc = 32'h300; set_pc(32'h0);
    step();
    arm = 1'b0;
    set_pc(32'h300); step();
    set_pc(32'h304); step();
    check("mid state", {30'd0, state}, 32'd2);
    check("mid count", {27'd0, count}, 32'd2);
    rst = 1'b1; arm = 1'b1; ready = 1'b1; set_pc(32'h308);
    step();
    check("rst state", {30'd0, state}, 32'd0);
    check("rst count", {27'd0, count}, 32'd0);
    check("rst valid", {31'd0, valid}, 32'd0);
    trig_pc = 32'h308;
    step();
    check("rst hold state", {30'd0, state}, 32'd0);
    check("rst hold count", {27'd0, count}, 32'd0);
    rst = 1'b0; arm = 1'b0; ready = 1'b0;

    // Trigger never matches; arm pulses while ARMED are ignored.
    arm = 1'b1; len = 8'd2; trig_pc = 32'hDEAD_BEE0; set_pc(32'h0);
    step();
    for (int i = 0; i < 50; i++) begin
      arm = (i % 7 == 0);
      set_pc(32'h1000 + 32'(4 * i));
      step();
      check($sformatf("nomatch st%0d", i), {30'd0, state}, 32'd1);
      check($sformatf("nomatch cnt%0d", i), {27'd0, count}, 32'd0);
    end
    arm = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
